// File: rtl/multi_pipe_arbiter_if.sv
// Requester-side bus of the shared-multiplier arbiter: operand requests in,
// one-hot grants and one-hot product responses out.
interface multi_pipe_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;

  // Requester (client datapath) view
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter view
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/multi_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among
// NREQ requesters. Requester IDs travel in a tag pipe alongside the
// multiplier so each product is routed back to the requester that issued it.
module multi_pipe_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arb_en,
  multi_pipe_arbiter_if.slave        bus,
  output logic                       mul_en_in,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_en_out,
  input  logic [2*WIDTH-1:0]         mul_out,
  output logic [$clog2(LAT+2):0]     inflight,
  output logic                       idle,
  output logic                       err_orphan
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned IW  = $clog2(LAT+2) + 1;
  localparam logic [IW-1:0] INF_MAX = IW'(LAT + 2);

  logic [IDW-1:0]     r_ptr;
  logic               r_mul_en;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_tv  [0:LAT];
  logic [IDW-1:0]     r_tid [0:LAT];
  logic [NREQ-1:0]    r_rsp_valid;
  logic [2*WIDTH-1:0] r_rsp_data;
  logic [IW-1:0]      r_inflight;
  logic               r_err;

  logic [NREQ-1:0]    w_grant;
  logic [IDW-1:0]     w_gid;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_head_v;
  logic [IDW-1:0]     w_head_id;

  assign w_head_v  = r_tv[LAT];
  assign w_head_id = r_tid[LAT];

  // Round-robin search from r_ptr upward with wrap; grants only a requesting index
  always_comb begin
    int unsigned w_idx;
    w_idx   = 0;
    w_grant = '0;
    w_gid   = '0;
    w_xfer  = 1'b0;
    if (!rst && arb_en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_idx = 32'(r_ptr) + k;
        if (w_idx >= NREQ) w_idx = w_idx - NREQ;
        if (!w_xfer && bus.req_valid[w_idx]) begin
          w_xfer = 1'b1;
          w_gid  = IDW'(w_idx);
        end
      end
      if (w_xfer) w_grant[w_gid] = 1'b1;
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    w_a = bus.req_a[32'(w_gid)*WIDTH +: WIDTH];
    w_b = bus.req_b[32'(w_gid)*WIDTH +: WIDTH];
  end

  // Issue stage: register granted operands toward the multiplier, advance pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_en <= 1'b0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_ptr    <= '0;
    end else begin
      r_mul_en <= w_xfer;
      r_mul_a  <= w_xfer ? w_a : '0;
      r_mul_b  <= w_xfer ? w_b : '0;
      if (w_xfer) r_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
    end
  end

  // Tag pipe: stage 0 lines up with mul_en_in, stage LAT with mul_en_out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        r_tv[i]  <= 1'b0;
        r_tid[i] <= '0;
      end
    end else begin
      r_tv[0]  <= w_xfer;
      r_tid[0] <= w_gid;
      for (int unsigned i = 1; i <= LAT; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tid[i] <= r_tid[i-1];
      end
    end
  end

  // Return path: route tagged products back; flag any tag/product disagreement
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      if (w_head_v && mul_en_out) begin
        r_rsp_valid[w_head_id] <= 1'b1;
        r_rsp_data             <= mul_out;
      end
      if (w_head_v != mul_en_out) r_err <= 1'b1;
    end
  end

  // Occupancy: issue adds one, any valid head leaving the tag pipe removes one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, w_head_v})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  a_inflight_bound: assert property (@(posedge clk) disable iff (rst) r_inflight <= INF_MAX);

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign mul_en_in     = r_mul_en;
  assign mul_a         = r_mul_a;
  assign mul_b         = r_mul_b;
  assign inflight      = r_inflight;
  assign idle          = (r_inflight == '0) && !r_mul_en;
  assign err_orphan    = r_err;
endmodule

// File: tb/tb_multi_pipe_arbiter.sv
// Bench for multi_pipe_arbiter: behavioural LAT-cycle multiplier, reference
// round-robin model and a response scoreboard, plus per-scenario tasks.
module tb_multi_pipe_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arb_en = 1'b0;
  logic mul_en_in, mul_en_out, idle, err_orphan;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_out;
  logic [$clog2(LAT+2):0] inflight;
  logic force_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;
  int mptr     = 0;

  typedef struct {
    int               due;
    int               id;
    logic [2*WIDTH-1:0] prod;
  } exp_t;
  exp_t sbq[$];

  multi_pipe_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  multi_pipe_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .bus        (bus),
    .mul_en_in  (mul_en_in),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en_out (mul_en_out),
    .mul_out    (mul_out),
    .inflight   (inflight),
    .idle       (idle),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  // Behavioural pipelined multiplier, reset together with the arbiter
  logic [LAT-1:0]     mm_v;
  logic [2*WIDTH-1:0] mm_p [LAT];
  always @(posedge clk) begin
    if (rst) begin
      mm_v <= '0;
      for (int i = 0; i < LAT; i++) mm_p[i] <= '0;
    end else begin
      mm_v    <= {mm_v[LAT-2:0], mul_en_in};
      mm_p[0] <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
      for (int i = 1; i < LAT; i++) mm_p[i] <= mm_p[i-1];
    end
  end
  assign mul_en_out = mm_v[LAT-1] | force_en;
  assign mul_out    = mm_v[LAT-1] ? mm_p[LAT-1] : '0;

  // Reference arbiter + scoreboard: checks every grant and every response slot
  always @(negedge clk) begin : mon
    int mg;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    logic [2*WIDTH-1:0] pa;
    logic [2*WIDTH-1:0] pb;
    exp_t e;
    ncyc++;
    if (rst) begin
      sbq.delete();
      mptr = 0;
    end else begin
      mg = -1;
      if (arb_en)
        for (int k = 0; k < NREQ; k++)
          if (mg < 0 && bus.req_valid[(mptr + k) % NREQ]) mg = (mptr + k) % NREQ;
      er = '0;
      if (mg >= 0) er[mg] = 1'b1;
      n_checks++;
      if (bus.req_ready !== er)
        $display("FAIL grant cyc=%0d got=%b exp=%b", ncyc, bus.req_ready, er);
      else n_pass++;
      if (sbq.size() > 0 && sbq[0].due == ncyc) begin
        e  = sbq.pop_front();
        ev = '0;
        ev[e.id] = 1'b1;
        n_checks++;
        if (bus.rsp_valid !== ev || bus.rsp_data !== e.prod)
          $display("FAIL rsp cyc=%0d got=%b/%0d exp=%b/%0d", ncyc, bus.rsp_valid, bus.rsp_data, ev, e.prod);
        else n_pass++;
      end else begin
        n_checks++;
        if (bus.rsp_valid !== '0 || bus.rsp_data !== '0)
          $display("FAIL rsp_idle cyc=%0d got=%b/%0d exp=0/0", ncyc, bus.rsp_valid, bus.rsp_data);
        else n_pass++;
      end
      if (mg >= 0) begin
        pa = {{WIDTH{1'b0}}, bus.req_a[mg*WIDTH +: WIDTH]};
        pb = {{WIDTH{1'b0}}, bus.req_b[mg*WIDTH +: WIDTH]};
        e.due  = ncyc + LAT + 2;
        e.id   = mg;
        e.prod = pa * pb;
        sbq.push_back(e);
        mptr = (mg + 1) % NREQ;
      end
    end
  end

  task automatic set_ops(input int i, input int a, input int b);
    bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    force_en = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    arb_en = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    arb_en = 1'b1;
    bus.req_valid = '1;
    bus.req_a = '1;
    bus.req_b = '1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); else n_pass++;
    n_checks++;
    if ({mul_en_in, mul_a, mul_b} !== '0) $display("FAIL reset_mul got=%b/%0d/%0d exp=0/0/0", mul_en_in, mul_a, mul_b); else n_pass++;
    n_checks++;
    if (bus.rsp_valid !== '0 || bus.rsp_data !== '0) $display("FAIL reset_rsp got=%b/%0d exp=0/0", bus.rsp_valid, bus.rsp_data); else n_pass++;
    n_checks++;
    if (inflight !== '0 || err_orphan !== 1'b0 || idle !== 1'b1)
      $display("FAIL reset_status got=%0d/%b/%b exp=0/0/1", inflight, err_orphan, idle);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    int lat;
    logic [NREQ-1:0] rv;
    logic [2*WIDTH-1:0] rd;
    lat = -1;
    rv = '0;
    rd = '0;
    do_reset();
    bus.req_valid = 4'b0001;
    set_ops(0, 13, 11);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (mul_en_in !== 1'b1 || mul_a !== 8'd13 || mul_b !== 8'd11)
      $display("FAIL single_issue got=%b/%0d/%0d exp=1/13/11", mul_en_in, mul_a, mul_b);
    else n_pass++;
    n_checks++;
    if (inflight !== 1 || idle !== 1'b0) $display("FAIL single_inflight got=%0d/%b exp=1/0", inflight, idle); else n_pass++;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (lat < 0 && bus.rsp_valid !== '0) begin
        lat = k;
        rv  = bus.rsp_valid;
        rd  = bus.rsp_data;
      end
    end
    n_checks++;
    if (lat != LAT + 2) $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 2); else n_pass++;
    n_checks++;
    if (rv !== 4'b0001 || rd !== 16'd143) $display("FAIL single_rsp got=%b/%0d exp=0001/143", rv, rd); else n_pass++;
    n_checks++;
    if (inflight !== 0 || idle !== 1'b1) $display("FAIL single_drain got=%0d/%b exp=0/1", inflight, idle); else n_pass++;
  endtask

  task automatic test_round_robin();
    int cnt;
    logic [NREQ-1:0] er;
    cnt = 0;
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 2, 3*i + 5);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 8) begin
        er = '0;
        er[c % NREQ] = 1'b1;
        n_checks++;
        if (bus.req_ready !== er) $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, er); else n_pass++;
      end
      if (bus.rsp_valid !== '0) begin
        er = '0;
        er[cnt % NREQ] = 1'b1;
        n_checks++;
        if (bus.rsp_valid !== er) $display("FAIL rr_rsp_order n=%0d got=%b exp=%b", cnt, bus.rsp_valid, er); else n_pass++;
        cnt++;
      end
      @(posedge clk); #1;
      if (c == 7) bus.req_valid = '0;
    end
    n_checks++;
    if (cnt != 8) $display("FAIL rr_rsp_count got=%0d exp=8", cnt); else n_pass++;
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req_valid = 4'b0010;
    set_ops(1, 7, 9);
    set_ops(3, 200, 100);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0010) $display("FAIL fair_first got=%b exp=0010", bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b1000) $display("FAIL fair_second got=%b exp=1000", bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0010) $display("FAIL fair_third got=%b exp=0010", bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int peak;
    int cnt;
    peak = 0;
    cnt = 0;
    do_reset();
    bus.req_valid = 4'b0100;
    set_ops(2, 255, 255);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (int'(inflight) > peak) peak = int'(inflight);
      if (bus.rsp_valid !== '0) begin
        n_checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'd65025)
          $display("FAIL b2b_rsp got=%b/%0d exp=0100/65025", bus.rsp_valid, bus.rsp_data);
        else n_pass++;
        cnt++;
      end
      @(posedge clk); #1;
      if (i == 2) bus.req_valid = '0;
    end
    n_checks++;
    if (peak != 3) $display("FAIL b2b_peak got=%0d exp=3", peak); else n_pass++;
    n_checks++;
    if (cnt != 3) $display("FAIL b2b_count got=%0d exp=3", cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    do_reset();
    bus.req_valid = 4'b0001;
    set_ops(0, 3, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    n_checks++;
    if (inflight !== 3) $display("FAIL rstmid_inflight got=%0d exp=3", inflight); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mul_en_in, mul_a, mul_b} !== '0 || bus.rsp_valid !== '0 || bus.rsp_data !== '0 ||
        inflight !== '0 || err_orphan !== 1'b0 || idle !== 1'b1)
      $display("FAIL rstmid_clear got=%b/%0d/%0d/%b/%0d/%0d/%b exp=all zero, idle=1",
               mul_en_in, mul_a, mul_b, bus.rsp_valid, bus.rsp_data, inflight, err_orphan);
    else n_pass++;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== '0) cnt++;
    end
    n_checks++;
    if (cnt != 0 || err_orphan !== 1'b0) $display("FAIL rstmid_no_rsp got=%0d/%b exp=0/0", cnt, err_orphan); else n_pass++;
  endtask

  task automatic test_orphan();
    do_reset();
    force_en = 1'b1;
    @(posedge clk); #1;
    force_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1 || bus.rsp_valid !== '0)
      $display("FAIL orphan_set got=%b/%b exp=1/0000", err_orphan, bus.rsp_valid);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1) $display("FAIL orphan_sticky got=%b exp=1", err_orphan); else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b0) $display("FAIL orphan_clear got=%b exp=0", err_orphan); else n_pass++;
  endtask

  task automatic test_arb_enable();
    int cnt;
    cnt = 0;
    do_reset();
    arb_en = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, 17*i + 1, 250 - i);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 4'b0000 || inflight !== 0) $display("FAIL arboff_ready got=%b/%0d exp=0000/0", bus.req_ready, inflight); else n_pass++;
      @(posedge clk); #1;
    end
    arb_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    arb_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL arb_drop got=%b exp=0000", bus.req_ready); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== '0) cnt++;
    end
    n_checks++;
    if (cnt != 2 || idle !== 1'b1) $display("FAIL arb_drain got=%0d/%b exp=2/1", cnt, idle); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = '0;
    arb_en = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
    test_orphan();
    test_arb_enable();
    repeat (LAT + 4) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) $display("FAIL sb_drain got=%0d exp=0", sbq.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
